// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability-counter debounce and an event FSM
// producing press / release / long-press pulses, a debounced level and an 8-bit press count.
module button_debounce #(
    parameter int ACTIVE_LOW      = 1,
    parameter int CNT_W           = 26,
    parameter int DEBOUNCE_CYCLES = 320000,
    parameter int LONG_CYCLES     = 32000000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       btn_in_i,
    output logic       btn_level_o,
    output logic       press_pulse_o,
    output logic       release_pulse_o,
    output logic       long_pulse_o,
    output logic [7:0] press_count_o
);

    // state        | meaning
    // RELEASED     | debounced released, idle
    // PRESS_WAIT   | pressed level seen, counting stable cycles
    // PRESSED      | press accepted, counting hold cycles
    // LONG         | long press already reported, waiting for release
    // RELEASE_WAIT | released level seen while pressed, counting stable cycles
    typedef enum logic [2:0] {
        S_RELEASED,
        S_PRESS_WAIT,
        S_PRESSED,
        S_LONG,
        S_RELEASE_WAIT
    } state_t;

    localparam logic             IDLE_LVL  = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             s;
    state_t           state_q;
    logic [CNT_W-1:0] dcnt_q;
    logic [CNT_W-1:0] hcnt_q;
    logic             long_done_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             long_q;
    logic [7:0]       count_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= {2{IDLE_LVL}};
        end else begin
            sync_q <= {sync_q[0], btn_in_i};
        end
    end

    assign s = sync_q[1] ^ IDLE_LVL;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_RELEASED;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            case (state_q)
                S_RELEASED: begin
                    if (s) begin
                        state_q <= S_PRESS_WAIT;
                        dcnt_q  <= '0;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!s) begin
                        state_q <= S_RELEASED;
                    end else if (dcnt_q == DB_LAST) begin
                        state_q     <= S_PRESSED;
                        press_q     <= 1'b1;
                        level_q     <= 1'b1;
                        count_q     <= count_q + 8'd1;
                        hcnt_q      <= '0;
                        long_done_q <= 1'b0;
                    end else begin
                        dcnt_q <= dcnt_q + CNT_ONE;
                    end
                end
                S_PRESSED: begin
                    if (!s) begin
                        state_q <= S_RELEASE_WAIT;
                        dcnt_q  <= '0;
                    end else if (hcnt_q == LONG_LAST) begin
                        state_q     <= S_LONG;
                        long_q      <= 1'b1;
                        long_done_q <= 1'b1;
                    end else begin
                        hcnt_q <= hcnt_q + CNT_ONE;
                    end
                end
                S_LONG: begin
                    if (!s) begin
                        state_q <= S_RELEASE_WAIT;
                        dcnt_q  <= '0;
                    end
                end
                S_RELEASE_WAIT: begin
                    // a bounce back to pressed resumes the hold phase without re-reporting
                    if (s) begin
                        state_q <= long_done_q ? S_LONG : S_PRESSED;
                    end else if (dcnt_q == DB_LAST) begin
                        state_q   <= S_RELEASED;
                        release_q <= 1'b1;
                        level_q   <= 1'b0;
                    end else begin
                        dcnt_q <= dcnt_q + CNT_ONE;
                    end
                end
                default: state_q <= S_RELEASED;
            endcase
        end
    end

    assign btn_level_o     = level_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
    assign long_pulse_o    = long_q;
    assign press_count_o   = count_q;

endmodule
